fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, PC loaded on reset.
REQ-002 Parameter MAX_INFLIGHT, default 2, max accepted-but-unanswered memory requests (1..3).
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 imem_req_valid  out  1  fetch request to instruction memory.
REQ-006 imem_req_ready  in  1  memory accepts request this cycle.
REQ-007 imem_req_addr  out  16  word address of request (current fetch PC).
REQ-008 imem_rsp_valid  in  1  read data valid; responses return in request order, at least 1 cycle after acceptance.
REQ-009 imem_rsp_data  in  32  instruction word.
REQ-010 inst_valid  out  1  instruction available to decode stage.
REQ-011 inst_ready  in  1  decode stage consumes instruction this cycle.
REQ-012 inst_data  out  32  instruction word.
REQ-013 inst_pc  out  16  address the instruction was fetched from.
REQ-014 redirect_valid  in  1  branch/jump taken; flush and refetch.
REQ-015 redirect_pc  in  16  new fetch address.

Function
REQ-016 Request accepted when imem_req_valid && imem_req_ready; fetch PC then increments by 1, 16'hFFFF wraps to 16'h0000.
REQ-017 imem_req_valid SHALL be 1 only when buffer occupancy + inflight < DEPTH and inflight < MAX_INFLIGHT and redirect_valid==0.
REQ-018 imem_req_valid/imem_req_addr SHALL hold stable while imem_req_ready==0, except on redirect.
REQ-019 Non-discarded response SHALL be written into the buffer tagged with its request PC; inst_valid rises the cycle after (1-cycle rsp-to-decode latency).
REQ-020 Buffer is FIFO; inst_valid = buffer non-empty; inst_data/inst_pc = head entry; pop on inst_valid && inst_ready.
REQ-021 inst_data/inst_pc SHALL hold stable while inst_valid && !inst_ready.
REQ-022 Redirect (one cycle): fetch PC <= redirect_pc, buffer emptied, drop count <= drop count + inflight (incl. a response arriving that same cycle's remaining), no request issued that cycle.
REQ-023 Responses arriving while drop count > 0 SHALL be discarded, decrementing drop count; new requests may issue during drain, their responses kept.
REQ-024 Redirect concurrent with an inst handshake: handshake completes (decode owns that instruction), buffer still flushed.
REQ-025 Redirect concurrent with response: response discarded.
REQ-026 Buffer full cannot overflow: guaranteed by REQ-017; push+pop same cycle on full buffer is legal.

Reset
REQ-027 On rst_n low: fetch PC=RESET_PC, buffer empty, inflight=0, drop=0, imem_req_valid=0, inst_valid=0, inst_data=0, inst_pc=0.
REQ-028 imem_req_valid SHALL assert the first clock edge after rst_n deasserts; reset mid-operation abandons all inflight requests.

Configuration
REQ-029 Macro FETCH_PREFETCH_EN defined: buffer DEPTH=2, back-to-back fetch with zero-bubble throughput of 1 inst/cycle at 1-cycle memory latency.
REQ-030 FETCH_PREFETCH_EN undefined: DEPTH=1, at most one inflight request regardless of MAX_INFLIGHT; max throughput 1 inst per 2 cycles.

Structure
REQ-031 Shared package cpu_pkg SHALL hold PC_W=16, INST_W=32, default RESET_PC, and fetch buffer entry struct {pc, inst}.
REQ-032 Buffer SHALL be a sub-module fetch_buffer (parameterised depth FIFO with flush input); counters and request logic in fetch_unit.

Verification
REQ-033 Reset release, ready=1, 1-cycle rsp latency, inst_ready=1 -> requests at 0,1,2,...; inst_pc 0,1,2 on consecutive cycles (macro on).
REQ-034 inst_ready=0 for 10 cycles -> inst_valid stays 1, inst_data/pc unchanged, requests stop once occupancy+inflight=DEPTH.
REQ-035 Two requests inflight (addr 4,5), redirect to 16'h0040 -> both responses dropped, next inst_pc=16'h0040.
REQ-036 Fetch PC 16'hFFFF accepted -> next imem_req_addr=16'h0000.
REQ-037 imem_req_ready=0 for 5 cycles -> imem_req_addr stable at same value, no duplicate inst.
REQ-038 rst_n asserted with 2 inflight -> all outputs zero immediately; after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU front-end widths, reset vector and fetch buffer entry type.
package cpu_pkg;

    localparam int PC_W   = 16;
    localparam int INST_W = 32;

    localparam logic [PC_W-1:0] DEFAULT_RESET_PC = 16'h0000;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Small FIFO of fetched {pc, inst} entries between memory and decode.
// Flush empties it in one cycle and takes priority over push/pop.
module fetch_buffer
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  fetch_entry_t  push_entry,
    input  logic          pop,
    output fetch_entry_t  head,
    output logic          empty,
    output logic [CW-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Storage rounded up to a power of two so the pointer width always indexes it cleanly.
    fetch_entry_t  mem [2**PW];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < 2**PW; i++) mem[i] <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC sequencing, request throttling, redirect flush and stale-response drain.
// Build macro FETCH_PREFETCH_EN selects a two-entry buffer with back-to-back fetch.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC     = DEFAULT_RESET_PC,
    parameter int              MAX_INFLIGHT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [PC_W-1:0]   imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [INST_W-1:0] imem_rsp_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst_data,
    output logic [PC_W-1:0]   inst_pc,
    input  logic              redirect_valid,
    input  logic [PC_W-1:0]   redirect_pc
);

`ifdef FETCH_PREFETCH_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif
    localparam int MAX_OUT = (DEPTH == 1) ? 1 : MAX_INFLIGHT;
    localparam int CW      = $clog2(DEPTH + 1);

    logic [PC_W-1:0] fetch_pc;
    logic [1:0]      live_cnt;   // requests issued since the last redirect, unanswered
    logic [1:0]      drop_cnt;   // pre-redirect requests whose responses must be discarded
    logic            started;

    logic            pop, req_fire, rsp_live, rsp_stale, push;
    logic [2:0]      occ_net;
    logic [CW-1:0]   buf_count;
    logic            buf_empty;
    fetch_entry_t    rsp_entry, buf_head;

    assign pop       = inst_valid && inst_ready;
    assign rsp_stale = imem_rsp_valid && (drop_cnt != 2'd0);
    assign rsp_live  = imem_rsp_valid && (drop_cnt == 2'd0);
    assign push      = rsp_live && !redirect_valid;

    // Occupancy counts this cycle's pop as already gone, which is what lets
    // the two-entry buffer sustain one instruction per cycle.
    assign occ_net = 3'(buf_count) - 3'(pop);

    assign imem_req_valid = started && !redirect_valid
                            && ((occ_net + 3'(live_cnt)) < 3'(DEPTH))
                            && ((3'(live_cnt) + 3'(drop_cnt)) < 3'(MAX_OUT));
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // Live requests are consecutive PCs ending just below fetch_pc, and stale
    // responses always drain first, so the oldest live PC tags the response.
    assign rsp_entry.pc   = fetch_pc - PC_W'(live_cnt);
    assign rsp_entry.inst = imem_rsp_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            started  <= 1'b0;
            fetch_pc <= RESET_PC;
            live_cnt <= '0;
            drop_cnt <= '0;
        end else begin
            started <= 1'b1;
            if (redirect_valid) begin
                fetch_pc <= redirect_pc;
                live_cnt <= '0;
                drop_cnt <= drop_cnt + live_cnt - 2'(imem_rsp_valid);
            end else begin
                if (req_fire) fetch_pc <= fetch_pc + PC_W'(1);
                live_cnt <= live_cnt + 2'(req_fire) - 2'(rsp_live);
                drop_cnt <= drop_cnt - 2'(rsp_stale);
            end
        end
    end

    fetch_buffer #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (redirect_valid),
        .push       (push),
        .push_entry (rsp_entry),
        .pop        (pop),
        .head       (buf_head),
        .empty      (buf_empty),
        .count      (buf_count)
    );

    assign inst_valid = !buf_empty;
    assign inst_data  = buf_head.inst;
    assign inst_pc    = buf_head.pc;

endmodule
